// File: rtl/main_memory.sv
// Word-addressed memory model behind the cache controller: accepts a one-cycle
// strobe, waits WAIT_STATES cycles, performs the access, then pulses MReady.
module main_memory #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int WAIT_STATES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MStrobe,
   input  logic              MRW,
   input  logic [ADDR_W-1:0] MAddr,
   input  logic [DATA_W-1:0] MDataIn,
   output logic [DATA_W-1:0] MDataOut,
   output logic              MReady,
   output logic              MBusy,
   output logic              ProtoErr,
   output logic [15:0]       ReqCount
);

   localparam int          DEPTH = 1 << ADDR_W;
   localparam logic [7:0]  WS    = 8'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                rw_q, rw_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic                perr_q, perr_d;
   logic [15:0]         req_q, req_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                accept;
   logic                access;
   logic                mem_we;

   assign accept = (state_q == S_IDLE) && MStrobe;
   assign access = (state_q == S_WAIT) && (cnt_q == '0);
   assign mem_we = access && rw_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (MStrobe) state_d = S_WAIT;
         S_WAIT:  if (cnt_q == '0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      MBusy  = (state_q != S_IDLE);
      MReady = (state_q == S_DONE);
   end

   // Request registers are loaded only at the accept edge, so later bus activity
   // cannot disturb an in-flight access.
   always_comb begin
      cnt_d  = cnt_q;
      addr_d = addr_q;
      data_d = data_q;
      rw_d   = rw_q;
      dout_d = dout_q;
      req_d  = req_q;
      perr_d = perr_q | (MStrobe && (state_q != S_IDLE));
      if (accept) begin
         addr_d = MAddr;
         data_d = MDataIn;
         rw_d   = MRW;
         cnt_d  = WS;
         req_d  = (req_q == 16'hFFFF) ? req_q : req_q + 16'd1;
      end
      if ((state_q == S_WAIT) && (cnt_q != '0)) begin
         cnt_d = cnt_q - 8'd1;
      end
      if (access && !rw_q) begin
         dout_d = mem_q[addr_q];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         addr_q <= '0;
         data_q <= '0;
         rw_q   <= 1'b0;
         dout_q <= '0;
         perr_q <= 1'b0;
         req_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
         data_q <= data_d;
         rw_q   <= rw_d;
         dout_q <= dout_d;
         perr_q <= perr_d;
         req_q  <= req_d;
      end
   end

   // Array has no reset; a reset mid-request forces IDLE so the write never fires.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[addr_q] <= data_q;
      end
   end

   assign MDataOut = dout_q;
   assign ProtoErr = perr_q;
   assign ReqCount = req_q;

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: a 4-wait-state and a 0-wait-state instance share one bus;
// transactions are checked against a transaction-level memory model.
module tb_main_memory;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       MStrobe = 1'b0;
   logic       MRW = 1'b0;
   logic [7:0] MAddr = '0;
   logic [7:0] MDataIn = '0;

   logic [7:0]  dout4, dout0;
   logic        rdy4, rdy0, busy4, busy0, perr4, perr0;
   logic [15:0] rc4, rc0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;

   logic [7:0] mem_m [256];
   bit         val_m [256];
   logic [7:0] last_rd = '0;
   int         cnt_m = 0;
   bit         perr_m = 1'b0;

   typedef struct {
      bit         rw;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[10];

   main_memory #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(4)) dut4 (
      .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr),
      .MDataIn(MDataIn), .MDataOut(dout4), .MReady(rdy4), .MBusy(busy4),
      .ProtoErr(perr4), .ReqCount(rc4)
   );

   main_memory #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr),
      .MDataIn(MDataIn), .MDataOut(dout0), .MReady(rdy0), .MBusy(busy0),
      .ProtoErr(perr0), .ReqCount(rc0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic rsel(input bit z);
      return z ? rdy0 : rdy4;
   endfunction
   function automatic logic bsel(input bit z);
      return z ? busy0 : busy4;
   endfunction
   function automatic logic esel(input bit z);
      return z ? perr0 : perr4;
   endfunction
   function automatic logic [7:0] dsel(input bit z);
      return z ? dout0 : dout4;
   endfunction
   function automatic logic [15:0] csel(input bit z);
      return z ? rc0 : rc4;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      cnt_m   = 0;
      perr_m  = 1'b0;
      last_rd = '0;
   endtask

   task automatic do_reset(input bit z);
      @(negedge clk);
      MStrobe = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("rst_busy",  bsel(z), 0);
      chk("rst_ready", rsel(z), 0);
      chk("rst_dout",  dsel(z), 0);
      chk("rst_perr",  esel(z), 0);
      chk("rst_count", csel(z), 0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      chk("post_rst_busy", bsel(z), 0);
   endtask

   // Called in the first window after the accept edge (or later, with a lower exp_lat).
   task automatic wait_done(input bit z, input int exp_lat);
      int lat = 0;
      bit busy_ok = 1'b1;
      while (lat < 300 && !rsel(z)) begin
         if (!bsel(z)) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (!bsel(z)) busy_ok = 1'b0;
      chk("ready_latency", lat, exp_lat);
      chk("busy_in_flight", busy_ok, 1);
   endtask

   task automatic post_idle(input bit z);
      @(negedge clk);
      chk("ready_one_cycle", rsel(z), 0);
      chk("busy_idle", bsel(z), 0);
      chk("req_count", csel(z), cnt_m);
      chk("proto_err", esel(z), perr_m);
   endtask

   task automatic xact(input bit z, input bit rw, input logic [7:0] a,
                       input logic [7:0] d, input bit wig);
      MStrobe = 1'b1; MRW = rw; MAddr = a; MDataIn = d;
      @(negedge clk);
      acc_cyc = cyc;
      MStrobe = 1'b0;
      if (wig) begin
         MAddr = a ^ 8'h01; MDataIn = ~d; MRW = ~rw;
      end
      if (cnt_m < 65535) cnt_m++;
      wait_done(z, z ? 1 : 5);
      if (rw) begin
         mem_m[a] = d;
         val_m[a] = 1'b1;
         chk("write_keeps_dout", dsel(z), last_rd);
      end else begin
         if (val_m[a]) last_rd = mem_m[a];
         chk("read_data", dsel(z), last_rd);
      end
      post_idle(z);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      logic [7:0] ra, rd;
      bit rrw, rwig;
      vec_t b2b[4];

      tbl[0] = '{1'b1, 8'h3C, 8'hA5, 8'h00};
      tbl[1] = '{1'b0, 8'h3C, 8'h00, 8'hA5};
      tbl[2] = '{1'b1, 8'h3D, 8'h5A, 8'h00};
      tbl[3] = '{1'b0, 8'h3D, 8'h00, 8'h5A};
      tbl[4] = '{1'b0, 8'h3C, 8'h00, 8'hA5};
      tbl[5] = '{1'b1, 8'hFF, 8'h00, 8'h00};
      tbl[6] = '{1'b0, 8'hFF, 8'h00, 8'h00};
      tbl[7] = '{1'b1, 8'h00, 8'hFF, 8'h00};
      tbl[8] = '{1'b0, 8'h00, 8'h00, 8'hFF};
      tbl[9] = '{1'b1, 8'h51, 8'h11, 8'h00};

      // Asynchronous reset asserted between clock edges.
      #2 reset = 1'b0;
      #1;
      chk("init_busy",  busy4, 0);
      chk("init_ready", rdy4, 0);
      chk("init_dout",  dout4, 0);
      chk("init_perr",  perr4, 0);
      chk("init_count", rc4, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      chk("init_post_busy", busy4, 0);

      foreach (tbl[i]) begin
         xact(1'b0, tbl[i].rw, tbl[i].a, tbl[i].d, 1'b0);
         if (!tbl[i].rw) chk("tbl_read", dout4, tbl[i].exp);
      end
      repeat (3) @(negedge clk);
      chk("dout_held", dout4, 8'hFF);

      // Second strobe while the first request is still waiting.
      MStrobe = 1'b1; MRW = 1'b1; MAddr = 8'h50; MDataIn = 8'h77;
      @(negedge clk);
      MAddr = 8'h51; MDataIn = 8'h99;
      cnt_m++;
      @(negedge clk);
      MStrobe = 1'b0;
      perr_m = 1'b1;
      wait_done(1'b0, 4);
      mem_m[8'h50] = 8'h77;
      val_m[8'h50] = 1'b1;
      post_idle(1'b0);
      xact(1'b0, 1'b0, 8'h50, 8'h00, 1'b0);
      chk("overlap_first", dout4, 8'h77);
      xact(1'b0, 1'b0, 8'h51, 8'h00, 1'b0);
      chk("overlap_ignored", dout4, 8'h11);

      // Bus wiggled right after acceptance.
      xact(1'b0, 1'b1, 8'h21, 8'h44, 1'b0);
      xact(1'b0, 1'b1, 8'h20, 8'hC3, 1'b1);
      xact(1'b0, 1'b0, 8'h20, 8'h00, 1'b0);
      chk("latched_addr", dout4, 8'hC3);
      xact(1'b0, 1'b0, 8'h21, 8'h00, 1'b0);
      chk("other_addr", dout4, 8'h44);

      for (int i = 0; i < 60; i++) begin
         ra   = 8'h80 | 8'($urandom_range(0, 15));
         rd   = 8'($urandom);
         rrw  = 1'($urandom_range(0, 1));
         rwig = 1'($urandom_range(0, 1));
         if (!val_m[ra]) rrw = 1'b1;
         xact(1'b0, rrw, ra, rd, rwig);
      end

      // Zero wait states, each request issued on the first IDLE cycle.
      do_reset(1'b1);
      b2b[0] = '{1'b1, 8'h01, 8'h12, 8'h00};
      b2b[1] = '{1'b0, 8'h01, 8'h00, 8'h12};
      b2b[2] = '{1'b1, 8'h02, 8'h34, 8'h00};
      b2b[3] = '{1'b0, 8'h02, 8'h00, 8'h34};
      prev = 0;
      foreach (b2b[i]) begin
         xact(1'b1, b2b[i].rw, b2b[i].a, b2b[i].d, 1'b0);
         if (i > 0) chk("b2b_spacing", acc_cyc - prev, 3);
         prev = acc_cyc;
         if (!b2b[i].rw) chk("b2b_read", dout0, b2b[i].exp);
      end

      // Reset during the WAIT phase of a write.
      do_reset(1'b0);
      xact(1'b0, 1'b1, 8'h10, 8'h11, 1'b0);
      MStrobe = 1'b1; MRW = 1'b1; MAddr = 8'h10; MDataIn = 8'hFF;
      @(negedge clk);
      MStrobe = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst_busy",  busy4, 0);
      chk("midrst_count", rc4, 0);
      chk("midrst_perr",  perr4, 0);
      chk("midrst_dout",  dout4, 0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      xact(1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
      chk("write_dropped", dout4, 8'h11);
      chk("count_after_rst", rc4, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
